// File: rtl/fetch_queue.sv
// Instruction fetch unit with a small FIFO of {instruction, pc+4} entries.
// It issues one memory read at a time, drops stale responses after a redirect, and feeds IF/ID.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                pc_initial,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t          state, state_nx;
  logic [31:0]     fetch_pc, fetch_pc_nx, redirect_aligned;
  logic [PW:0]     count_nx;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            ack, push, pop;

  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc4_mem   [DEPTH];

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    ack         = imem_req & imem_ack;
    push        = (state == FETCH) & ack & ~redirect;
    pop         = out_valid & deq & ~redirect;
    unique case (state)
      IDLE: begin
        state_nx    = FETCH;
        fetch_pc_nx = redirect ? redirect_aligned : (pc_initial & 32'hFFFF_FFFC);
      end
      FETCH: begin
        if (redirect) begin
          fetch_pc_nx = redirect_aligned;
          if (imem_req && !imem_ack) state_nx = DROP;
        end else if (push) begin
          fetch_pc_nx = fetch_pc + 32'd4;
        end
      end
      DROP: begin
        if (redirect) fetch_pc_nx = redirect_aligned;
        if (imem_ack) state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
    if (redirect) count_nx = '0;
    else          count_nx = count + (PW+1)'(push) - (PW+1)'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      count    <= count_nx;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      // DROP keeps presenting the abandoned request until memory answers it.
      imem_req  <= (state_nx == DROP) || (state_nx == FETCH && count_nx < FULL);
      imem_addr <= (state_nx == DROP) ? imem_addr : fetch_pc_nx;
    end
  end

  // NOTE: storage array has no reset; count gates visibility so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc4_mem[wr_ptr]   <= fetch_pc + 32'd4;
    end
  end

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'd0;
  assign out_pc4   = out_valid ? pc4_mem[rd_ptr]   : 32'd0;

endmodule
